// File: rtl/dec_pkg.sv
// Shared decode definitions: RV32I opcodes, micro-op layout, immediate formats
// and the occupancy states of the decode-stage buffer.
`timescale 1ns/1ps
package dec_pkg;

   localparam logic [6:0] OPC_LOAD     = 7'h03;
   localparam logic [6:0] OPC_MISC_MEM = 7'h0F;
   localparam logic [6:0] OPC_OP_IMM   = 7'h13;
   localparam logic [6:0] OPC_AUIPC    = 7'h17;
   localparam logic [6:0] OPC_STORE    = 7'h23;
   localparam logic [6:0] OPC_OP       = 7'h33;
   localparam logic [6:0] OPC_LUI      = 7'h37;
   localparam logic [6:0] OPC_BRANCH   = 7'h63;
   localparam logic [6:0] OPC_JALR     = 7'h67;
   localparam logic [6:0] OPC_JAL      = 7'h6F;
   localparam logic [6:0] OPC_SYSTEM   = 7'h73;

   localparam logic [2:0] F3_ADD = 3'b000;
   localparam logic [2:0] F3_SLL = 3'b001;
   localparam logic [2:0] F3_SRL = 3'b101;

   localparam logic [6:0] F7_BASE = 7'h00;
   localparam logic [6:0] F7_ALT  = 7'h20;

   localparam int UOP_W = 68;

   // First member is the MSB of the packed word.
   typedef struct packed {
      logic        illegal;
      logic [6:0]  opcode;
      logic [4:0]  rd;
      logic [4:0]  rs1;
      logic [4:0]  rs2;
      logic [2:0]  funct3;
      logic [6:0]  funct7;
      logic [31:0] imm;
      logic        rd_we;
      logic        rs1_used;
      logic        rs2_used;
   } uop_t;

   typedef enum logic [2:0] {
      IMM_I,
      IMM_S,
      IMM_B,
      IMM_U,
      IMM_J,
      IMM_NONE
   } imm_fmt_t;

   // Buffer occupancy: nothing held, main register only, main plus skid.
   typedef enum logic [1:0] {
      OCC_EMPTY,
      OCC_MAIN,
      OCC_BOTH
   } occ_t;

   // Build the sign-extended immediate for a given instruction format.
   function automatic logic [31:0] gen_imm(input logic [31:0] inst, input imm_fmt_t fmt);
      logic [31:0] imm;
      imm = '0;
      case (fmt)
         IMM_I:   imm = {{20{inst[31]}}, inst[31:20]};
         IMM_S:   imm = {{20{inst[31]}}, inst[31:25], inst[11:7]};
         IMM_B:   imm = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
         IMM_U:   imm = {inst[31:12], 12'b0};
         IMM_J:   imm = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
         default: imm = '0;
      endcase
      return imm;
   endfunction

endpackage

// File: rtl/decode_stage_multi_if.sv
// Fetch-side and consumer-side bundle signals of the decode stage.
// Handshake: a bundle moves across a boundary on a rising clk edge where its
// valid and ready are both high; a producer holding valid=1 keeps its payload
// stable until that edge, and valid never waits on ready.
`timescale 1ns/1ps
interface decode_stage_multi_if
   import dec_pkg::*;
#(
   parameter int NUM_LANES = 2,
   parameter int PC_W      = 32
);

   logic                         in_valid;
   logic                         in_ready;
   logic [NUM_LANES*32-1:0]      in_inst;
   logic [NUM_LANES-1:0]         in_lane_valid;
   logic [PC_W-1:0]              in_pc;

   logic                         out_valid;
   logic                         out_ready;
   logic [NUM_LANES*UOP_W-1:0]   out_uop;
   logic [NUM_LANES-1:0]         out_lane_valid;
   logic [PC_W-1:0]              out_pc;

   // Buffer occupancy, exported for observation.
   occ_t                         state;

   modport master (
      output in_valid, in_inst, in_lane_valid, in_pc, out_ready,
      input  in_ready, out_valid, out_uop, out_lane_valid, out_pc, state
   );

   modport slave (
      input  in_valid, in_inst, in_lane_valid, in_pc, out_ready,
      output in_ready, out_valid, out_uop, out_lane_valid, out_pc, state
   );

endinterface

// File: rtl/decode_lane.sv
// Combinational RV32I decoder for a single instruction slot.
`timescale 1ns/1ps
module decode_lane
   import dec_pkg::*;
(
   input  logic [31:0] inst,
   input  logic        lane_valid,
   output uop_t        uop
);

   logic [6:0] opc;
   logic [2:0] f3;
   logic [6:0] f7;

   assign opc = inst[6:0];
   assign f3  = inst[14:12];
   assign f7  = inst[31:25];

   logic     known_opc;
   logic     bad_fn;
   logic     keep_rd;
   logic     keep_rs1;
   logic     keep_rs2;
   logic     keep_f3;
   logic     keep_f7;
   logic     use_rd;
   logic     use_rs1;
   logic     use_rs2;
   imm_fmt_t fmt;

   // Classify the opcode: which fields are meaningful, which registers are used,
   // which immediate format applies, and whether funct bits are legal.
   // Unknown opcodes keep their raw register/funct fields but use nothing.
   always_comb begin
      known_opc = 1'b1;
      bad_fn    = 1'b0;
      keep_rd   = 1'b0;
      keep_rs1  = 1'b0;
      keep_rs2  = 1'b0;
      keep_f3   = 1'b0;
      keep_f7   = 1'b0;
      use_rd    = 1'b0;
      use_rs1   = 1'b0;
      use_rs2   = 1'b0;
      fmt       = IMM_NONE;
      case (opc)
         OPC_OP: begin
            keep_rd  = 1'b1;
            keep_rs1 = 1'b1;
            keep_rs2 = 1'b1;
            keep_f3  = 1'b1;
            keep_f7  = 1'b1;
            use_rd   = 1'b1;
            use_rs1  = 1'b1;
            use_rs2  = 1'b1;
            bad_fn   = !((f7 == F7_BASE) || (f7 == F7_ALT)) ||
                       ((f7 == F7_ALT) && !((f3 == F3_ADD) || (f3 == F3_SRL)));
         end
         OPC_OP_IMM: begin
            keep_rd  = 1'b1;
            keep_rs1 = 1'b1;
            keep_f3  = 1'b1;
            use_rd   = 1'b1;
            use_rs1  = 1'b1;
            fmt      = IMM_I;
            // Shifts carry the shamt in imm[4:0]; the upper field selects SRLI/SRAI.
            if (f3 == F3_SLL) begin
               keep_f7 = 1'b1;
               bad_fn  = (f7 != F7_BASE);
            end else if (f3 == F3_SRL) begin
               keep_f7 = 1'b1;
               bad_fn  = !((f7 == F7_BASE) || (f7 == F7_ALT));
            end
         end
         OPC_LOAD, OPC_JALR: begin
            keep_rd  = 1'b1;
            keep_rs1 = 1'b1;
            keep_f3  = 1'b1;
            use_rd   = 1'b1;
            use_rs1  = 1'b1;
            fmt      = IMM_I;
         end
         OPC_STORE: begin
            keep_rs1 = 1'b1;
            keep_rs2 = 1'b1;
            keep_f3  = 1'b1;
            use_rs1  = 1'b1;
            use_rs2  = 1'b1;
            fmt      = IMM_S;
         end
         OPC_BRANCH: begin
            keep_rs1 = 1'b1;
            keep_rs2 = 1'b1;
            keep_f3  = 1'b1;
            use_rs1  = 1'b1;
            use_rs2  = 1'b1;
            fmt      = IMM_B;
         end
         OPC_LUI, OPC_AUIPC: begin
            keep_rd = 1'b1;
            use_rd  = 1'b1;
            fmt     = IMM_U;
         end
         OPC_JAL: begin
            keep_rd = 1'b1;
            use_rd  = 1'b1;
            fmt     = IMM_J;
         end
         OPC_MISC_MEM: begin
            keep_f3 = 1'b1;
         end
         OPC_SYSTEM: begin
            // CSR ops: imm carries the CSR address; register source only for
            // the non-immediate CSR variants.
            keep_rd  = 1'b1;
            keep_rs1 = 1'b1;
            keep_f3  = 1'b1;
            use_rd   = 1'b1;
            use_rs1  = !f3[2] && (f3[1:0] != 2'b00);
            fmt      = IMM_I;
         end
         default: begin
            known_opc = 1'b0;
            keep_rd   = 1'b1;
            keep_rs1  = 1'b1;
            keep_rs2  = 1'b1;
            keep_f3   = 1'b1;
            keep_f7   = 1'b1;
         end
      endcase
   end

   // Assemble the micro-op; a masked-off slot is all zeros.
   always_comb begin
      uop = '0;
      if (lane_valid) begin
         uop.illegal  = !known_opc || (inst[1:0] != 2'b11) || bad_fn;
         uop.opcode   = opc;
         uop.rd       = keep_rd  ? inst[11:7]  : 5'd0;
         uop.rs1      = keep_rs1 ? inst[19:15] : 5'd0;
         uop.rs2      = keep_rs2 ? inst[24:20] : 5'd0;
         uop.funct3   = keep_f3  ? f3          : 3'd0;
         uop.funct7   = keep_f7  ? f7          : 7'd0;
         uop.imm      = gen_imm(inst, fmt);
         uop.rd_we    = use_rd && (inst[11:7] != 5'd0);
         uop.rs1_used = use_rs1;
         uop.rs2_used = use_rs2;
      end
   end

endmodule

// File: rtl/decode_stage_multi.sv
// N-lane decode stage: registers raw fetch bundles in a main register backed by
// a one-entry skid buffer, and decodes the main register combinationally.
`timescale 1ns/1ps
module decode_stage_multi
   import dec_pkg::*;
#(
   parameter int NUM_LANES = 2,
   parameter int PC_W      = 32,
   parameter int SKID_EN   = 1
)(
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  kill,
   decode_stage_multi_if.slave   bus
);

   occ_t                    state;
   logic [NUM_LANES*32-1:0] main_inst;
   logic [NUM_LANES-1:0]    main_mask;
   logic [PC_W-1:0]         main_pc;
   logic [NUM_LANES*32-1:0] skid_inst;
   logic [NUM_LANES-1:0]    skid_mask;
   logic [PC_W-1:0]         skid_pc;

   logic in_xfer;

   // With the skid present in_ready depends only on registered state; without
   // it the stage can only accept when the main register is free or draining.
   assign bus.in_ready = (SKID_EN != 0) ? (state != OCC_BOTH)
                                        : (bus.out_ready || (state == OCC_EMPTY));

   assign in_xfer = bus.in_valid && bus.in_ready && !kill;

   // Occupancy FSM with main/skid payload registers; kill wins over everything.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state     <= OCC_EMPTY;
         main_inst <= '0;
         main_mask <= '0;
         main_pc   <= '0;
         skid_inst <= '0;
         skid_mask <= '0;
         skid_pc   <= '0;
      end else if (kill) begin
         state <= OCC_EMPTY;
      end else begin
         case (state)
            OCC_EMPTY: begin
               if (in_xfer) begin
                  main_inst <= bus.in_inst;
                  main_mask <= bus.in_lane_valid;
                  main_pc   <= bus.in_pc;
                  state     <= OCC_MAIN;
               end
            end
            OCC_MAIN: begin
               if (in_xfer && bus.out_ready) begin
                  // Drain and reload in the same cycle.
                  main_inst <= bus.in_inst;
                  main_mask <= bus.in_lane_valid;
                  main_pc   <= bus.in_pc;
               end else if (in_xfer) begin
                  // Consumer stalled: park the new bundle behind the main one.
                  skid_inst <= bus.in_inst;
                  skid_mask <= bus.in_lane_valid;
                  skid_pc   <= bus.in_pc;
                  state     <= OCC_BOTH;
               end else if (bus.out_ready) begin
                  state <= OCC_EMPTY;
               end
            end
            OCC_BOTH: begin
               if (bus.out_ready) begin
                  main_inst <= skid_inst;
                  main_mask <= skid_mask;
                  main_pc   <= skid_pc;
                  state     <= OCC_MAIN;
               end
            end
            default: state <= OCC_EMPTY;
         endcase
      end
   end

   assign bus.out_valid      = (state != OCC_EMPTY);
   assign bus.out_lane_valid = main_mask;
   assign bus.out_pc         = main_pc;
   assign bus.state          = state;

   // One decoder per lane on the main register contents.
   for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
      uop_t lane_uop;

      decode_lane u_lane (
         .inst       (main_inst[l*32 +: 32]),
         .lane_valid (main_mask[l]),
         .uop        (lane_uop)
      );

      assign bus.out_uop[l*UOP_W +: UOP_W] = lane_uop;
   end

endmodule

// File: tb/tb_decode_stage_multi.sv
// Bench for decode_stage_multi: vector table through a scoreboard, plus
// back-pressure, kill and asynchronous reset sequences.
`timescale 1ns/1ps
module tb_decode_stage_multi;
   import dec_pkg::*;

   localparam int NL = 2;
   localparam int BW = NL*UOP_W + NL + 32;
   localparam int NV = 10;

   typedef struct {
      logic [NL*32-1:0] inst;
      logic [NL-1:0]    mask;
      logic [31:0]      pc;
      uop_t             u0;
      uop_t             u1;
   } vec_t;

   logic clk;
   logic reset_n;
   logic kill;
   int   ready_mode;
   int   checks;
   int   errors;

   vec_t            vecs[NV];
   logic [BW-1:0]   exp_q[$];
   logic [BW-1:0]   cur_exp;
   logic [BW-1:0]   e;
   logic            hold_prev;
   logic [NL*UOP_W-1:0] hold_uop;
   logic [31:0]     hold_pc;
   logic [NL-1:0]   hold_mask;
   uop_t            l0;
   uop_t            l1;

   decode_stage_multi_if #(.NUM_LANES(NL), .PC_W(32)) bus ();

   decode_stage_multi #(.NUM_LANES(NL), .PC_W(32), .SKID_EN(1)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .kill    (kill),
      .bus     (bus)
   );

   // Clock and watchdog.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #100000;
      $display("FAIL watchdog actual=running required=finished");
      $fatal(1, "watchdog expired");
   end

   // Consumer ready: 0 = stalled, 1 = always ready, otherwise random.
   always @(posedge clk) begin
      #1;
      case (ready_mode)
         0:       bus.out_ready = 1'b0;
         1:       bus.out_ready = 1'b1;
         default: bus.out_ready = ($urandom_range(0, 3) != 0);
      endcase
   end

   task automatic chk(input string name, input logic [191:0] act, input logic [191:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   // Scoreboard: sampled on the falling edge, i.e. before the rising edge that
   // performs the transfers seen here.
   always @(negedge clk) begin
      if (!reset_n) begin
         exp_q.delete();
         hold_prev = 1'b0;
      end else begin
         if (hold_prev) begin
            chk("hold_uop", bus.out_uop, hold_uop);
            chk("hold_pc", bus.out_pc, hold_pc);
            chk("hold_mask", bus.out_lane_valid, hold_mask);
         end
         if (bus.out_valid && bus.out_ready && !kill) begin
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_out actual_pc=%0h required=none", bus.out_pc);
            end else begin
               e = exp_q.pop_front();
               chk("out_lane0", bus.out_uop[UOP_W-1:0], e[UOP_W-1:0]);
               chk("out_lane1", bus.out_uop[2*UOP_W-1:UOP_W], e[2*UOP_W-1:UOP_W]);
               chk("out_mask", bus.out_lane_valid, e[2*UOP_W+NL-1:2*UOP_W]);
               chk("out_pc", bus.out_pc, e[BW-1:2*UOP_W+NL]);
            end
         end
         if (kill) exp_q.delete();
         else if (bus.in_valid && bus.in_ready) exp_q.push_back(cur_exp);
         hold_prev = bus.out_valid && !bus.out_ready && !kill;
         hold_uop  = bus.out_uop;
         hold_pc   = bus.out_pc;
         hold_mask = bus.out_lane_valid;
      end
   end

   function automatic uop_t mk(input logic il, input logic [6:0] op, input logic [4:0] rd,
                               input logic [4:0] rs1, input logic [4:0] rs2, input logic [2:0] f3,
                               input logic [6:0] f7, input logic [31:0] imm, input logic we,
                               input logic r1, input logic r2);
      uop_t u;
      u.illegal  = il;
      u.opcode   = op;
      u.rd       = rd;
      u.rs1      = rs1;
      u.rs2      = rs2;
      u.funct3   = f3;
      u.funct7   = f7;
      u.imm      = imm;
      u.rd_we    = we;
      u.rs1_used = r1;
      u.rs2_used = r2;
      return u;
   endfunction

   // Advance n cycles, landing just after the rising edge.
   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic drive(input int i);
      bus.in_inst       = vecs[i].inst;
      bus.in_lane_valid = vecs[i].mask;
      bus.in_pc         = vecs[i].pc;
      cur_exp           = {vecs[i].pc, vecs[i].mask, vecs[i].u1, vecs[i].u0};
      bus.in_valid      = 1'b1;
   endtask

   task automatic send(input int i);
      int n;
      drive(i);
      n = 0;
      @(negedge clk);
      while (!bus.in_ready && n < 50) begin
         n++;
         @(negedge clk);
      end
      if (!bus.in_ready) begin
         checks++;
         errors++;
         $display("FAIL send_timeout actual=in_ready_low required=accept vec=%0d", i);
      end
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
   endtask

   task automatic drain();
      int n;
      ready_mode = 1;
      n = 0;
      while (exp_q.size() != 0 && n < 100) begin
         n++;
         step(1);
      end
      chk("drain_queue", exp_q.size(), 0);
      step(1);
      chk("drain_out_valid", bus.out_valid, 1'b0);
   endtask

   initial begin
      checks        = 0;
      errors        = 0;
      reset_n       = 1'b0;
      kill          = 1'b0;
      ready_mode    = 0;
      hold_prev     = 1'b0;
      bus.in_valid  = 1'b0;
      bus.in_inst   = '0;
      bus.in_lane_valid = '0;
      bus.in_pc     = '0;
      cur_exp       = '0;

      // {lane1, lane0} instruction pairs with hand-derived micro-ops.
      vecs[0] = '{inst: {32'h0021A423, 32'hFFF00093}, mask: 2'b11, pc: 32'h0000_0100,
                  u0: mk(0, 7'h13, 1, 0, 0, 0, 7'h00, 32'hFFFFFFFF, 1, 1, 0),
                  u1: mk(0, 7'h23, 0, 3, 2, 2, 7'h00, 32'h00000008, 0, 1, 1)};
      vecs[1] = '{inst: {32'hFE000EE3, 32'h8000006F}, mask: 2'b11, pc: 32'h0000_2000,
                  u0: mk(0, 7'h6F, 0, 0, 0, 0, 7'h00, 32'hFFF00000, 0, 0, 0),
                  u1: mk(0, 7'h63, 0, 0, 0, 0, 7'h00, 32'hFFFFFFFC, 0, 1, 1)};
      vecs[2] = '{inst: {32'h027302B3, 32'h00000000}, mask: 2'b11, pc: 32'h0000_3000,
                  u0: mk(1, 7'h00, 0, 0, 0, 0, 7'h00, 32'h00000000, 0, 0, 0),
                  u1: mk(1, 7'h33, 5, 6, 7, 0, 7'h01, 32'h00000000, 1, 1, 1)};
      vecs[3] = '{inst: {32'hFFF00093, 32'h002081B3}, mask: 2'b01, pc: 32'h0000_4000,
                  u0: mk(0, 7'h33, 3, 1, 2, 0, 7'h00, 32'h00000000, 1, 1, 1),
                  u1: '0};
      vecs[4] = '{inst: {32'h40629233, 32'h40628233}, mask: 2'b11, pc: 32'h0000_5000,
                  u0: mk(0, 7'h33, 4, 5, 6, 0, 7'h20, 32'h00000000, 1, 1, 1),
                  u1: mk(1, 7'h33, 4, 5, 6, 1, 7'h20, 32'h00000000, 1, 1, 1)};
      vecs[5] = '{inst: {32'h00001017, 32'hABCDE3B7}, mask: 2'b11, pc: 32'hFFFF_FFFC,
                  u0: mk(0, 7'h37, 7, 0, 0, 0, 7'h00, 32'hABCDE000, 1, 0, 0),
                  u1: mk(0, 7'h17, 0, 0, 0, 0, 7'h00, 32'h00001000, 0, 0, 0)};
      vecs[6] = '{inst: {32'h40311093, 32'h40315093}, mask: 2'b11, pc: 32'h0000_6000,
                  u0: mk(0, 7'h13, 1, 2, 0, 5, 7'h20, 32'h00000403, 1, 1, 0),
                  u1: mk(1, 7'h13, 1, 2, 0, 1, 7'h20, 32'h00000403, 1, 1, 0)};
      vecs[7] = '{inst: {32'h000280E7, 32'hFFC4A403}, mask: 2'b11, pc: 32'h0000_7000,
                  u0: mk(0, 7'h03, 8, 9, 0, 2, 7'h00, 32'hFFFFFFFC, 1, 1, 0),
                  u1: mk(0, 7'h67, 1, 5, 0, 0, 7'h00, 32'h00000000, 1, 1, 0)};
      vecs[8] = '{inst: {32'h00000073, 32'h0FF0000F}, mask: 2'b11, pc: 32'h0000_8000,
                  u0: mk(0, 7'h0F, 0, 0, 0, 0, 7'h00, 32'h00000000, 0, 0, 0),
                  u1: mk(0, 7'h73, 0, 0, 0, 0, 7'h00, 32'h00000000, 0, 0, 0)};
      vecs[9] = '{inst: {32'h00209863, 32'hFFF00090}, mask: 2'b11, pc: 32'h0000_9000,
                  u0: mk(1, 7'h10, 1, 0, 31, 0, 7'h7F, 32'h00000000, 0, 0, 0),
                  u1: mk(0, 7'h63, 0, 1, 2, 1, 7'h00, 32'h00000010, 0, 1, 1)};

      // Reset state.
      step(3);
      chk("rst_out_valid", bus.out_valid, 1'b0);
      chk("rst_in_ready", bus.in_ready, 1'b1);
      chk("rst_out_pc", bus.out_pc, 32'h0);
      chk("rst_out_mask", bus.out_lane_valid, 2'b00);
      chk("rst_out_uop", bus.out_uop, '0);
      chk("rst_state", bus.state, OCC_EMPTY);
      reset_n = 1'b1;
      step(1);

      // First bundle appears the cycle after acceptance.
      send(0);
      l0 = bus.out_uop[UOP_W-1:0];
      l1 = bus.out_uop[2*UOP_W-1:UOP_W];
      chk("t1_out_valid", bus.out_valid, 1'b1);
      chk("t1_out_pc", bus.out_pc, 32'h100);
      chk("t1_l0_imm", l0.imm, 32'hFFFFFFFF);
      chk("t1_l0_rd", l0.rd, 5'd1);
      chk("t1_l0_rd_we", l0.rd_we, 1'b1);
      chk("t1_l1_imm", l1.imm, 32'h8);
      chk("t1_l1_rs2_used", l1.rs2_used, 1'b1);
      chk("t1_l1_rd_we", l1.rd_we, 1'b0);
      drain();

      // Vector table under random consumer stalls.
      ready_mode = 2;
      for (int i = 0; i < NV; i++) begin
         send(i);
         step($urandom_range(0, 1));
      end
      drain();

      // Back-pressure: two bundles accepted while stalled, third refused.
      ready_mode = 0;
      step(1);
      send(2);
      send(3);
      chk("bp_state", bus.state, OCC_BOTH);
      drive(4);
      for (int k = 0; k < 2; k++) begin
         @(negedge clk);
         chk("bp_in_ready", bus.in_ready, 1'b0);
         chk("bp_out_pc", bus.out_pc, vecs[2].pc);
      end
      step(1);
      ready_mode = 1;
      send(4);
      drain();

      // Kill with main and skid full while a bundle is offered.
      ready_mode = 0;
      step(1);
      send(5);
      send(6);
      drive(7);
      kill = 1'b1;
      step(1);
      kill = 1'b0;
      bus.in_valid = 1'b0;
      chk("kill_full_out_valid", bus.out_valid, 1'b0);
      chk("kill_full_in_ready", bus.in_ready, 1'b1);

      // Kill while the offered bundle would otherwise be accepted.
      send(8);
      drive(9);
      kill = 1'b1;
      step(1);
      kill = 1'b0;
      bus.in_valid = 1'b0;
      chk("kill_main_out_valid", bus.out_valid, 1'b0);
      chk("kill_main_state", bus.state, OCC_EMPTY);
      ready_mode = 1;
      send(1);
      drain();

      // Asynchronous reset with the skid full.
      ready_mode = 0;
      step(1);
      send(0);
      send(1);
      #2;
      reset_n = 1'b0;
      #1;
      chk("arst_out_valid", bus.out_valid, 1'b0);
      chk("arst_in_ready", bus.in_ready, 1'b1);
      @(posedge clk);
      #1;
      reset_n = 1'b1;
      step(1);
      chk("arst_rel_out_valid", bus.out_valid, 1'b0);
      chk("arst_rel_state", bus.state, OCC_EMPTY);
      chk("arst_rel_in_ready", bus.in_ready, 1'b1);
      ready_mode = 1;
      send(3);
      drain();

      chk("final_queue", exp_q.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
